mips_pipelined_core: RTL and testbench
======================================

# mips_pipelined_core

Five-stage pipelined MIPS32-subset processor core: Fetch, Decode, Execute, Memory, Writeback. It sits between an external instruction memory and an external data memory in the top-level system. Both memories are combinational-read. The data memory writes synchronously on the rising clock edge when `memwrite` is high. The core resolves data hazards with forwarding and stalls, and resolves control hazards in Decode with a one-instruction squash.

## Interface
- No parameters.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pc` out 32: Fetch-stage program counter, byte address; the instruction memory is indexed by `pc[7:2]`.
- `instr` in 32: instruction word at `pc`, valid in the same cycle (combinational).
- `memwrite` out 1: store enable from the Memory stage.
- `aluout` out 32: Memory-stage ALU result, used as the data-memory byte address.
- `writedata` out 32: Memory-stage store data (forwarded rt value).
- `readdata` in 32: data-memory word at `aluout`, combinational.

## Operation
- Supported instructions (opcode/funct, hex):
  - R-type (op 00): add 20, sub 22, and 24, or 25, slt 2A.
  - lw 23, sw 2B, beq 04, addi 08, j 02.
  - Any other opcode or funct decodes as a nop: no register write, no memory write, no branch.
- Arithmetic and immediates:
  - 32-bit two's-complement arithmetic; add/sub wrap with no overflow trap.
  - slt is a signed compare and produces 0 or 1.
  - Immediates are sign-extended.
  - Address = rs + signext(imm).
- Branch and jump targets:
  - Branch target = PC+4 + (signext(imm) << 2).
  - Jump target = {PC+4[31:28], instr[25:0], 2'b00}.
- Register file:
  - 32×32 registers with 2 combinational read ports and 1 write port.
  - `$0` always reads 0; writes to it are ignored.
  - Write-through: a register written in Writeback returns the new value to a Decode read in the same cycle.
- Writeback:
  - Destination is rd for R-type and rt for lw/addi.
  - Result is `readdata` for lw, otherwise the ALU result.
- Forwarding to Execute operands (rs, rt), nonzero register match only:
  - A Memory-stage match with regwrite takes priority, forwarding `aluout`.
  - Otherwise a Writeback-stage match with regwrite forwards the Writeback result.
  - Otherwise the operand comes from the register file.
- Branch handling:
  - beq is compared in Decode.
  - Decode operands are forwarded from the Memory-stage ALU result when rs/rt matches the Memory destination (nonzero, regwrite).
- Stalls (the PC and the F/D register hold, and the D/E register is flushed to a bubble):
  - Load-use: the Execute instruction is lw, and its rt equals the Decode instruction's rs or rt.
  - Branch: Decode is beq and either:
    - Execute writes a register equal to rs or rt, or
    - Memory is lw and its rt equals rs or rt.
- Control transfer:
  - beq taken or j in Decode: the PC loads the target on the next edge.
  - The instruction currently in Fetch is squashed (F/D cleared to a nop); there is no architectural delay slot.
  - When a stall and a taken branch coincide, the stall wins: the branch is re-evaluated next cycle.

## Timing
- PC update:
  - The PC advances by 4 on each rising edge unless stalled.
  - Fetch is combinational, so `pc` → `instr` resolves in the same cycle.
- Store latency: a sw fetched at cycle N drives `memwrite`=1 with `aluout`/`writedata` during cycle N+3 (no stalls); the memory write occurs on the edge ending that cycle.
- Load latency: a lw's result is written to the register file in cycle N+4 and is visible to Decode in that cycle.
- Reset (`reset`=0, asynchronous):
  - `pc`=0.
  - All pipeline registers are cleared to nops: `memwrite`=0, `aluout`=0, `writedata`=0.
  - All 32 registers are cleared to 0.
  - The first fetch after release is address 0.
- Reset asserted mid-operation aborts all in-flight instructions immediately; an in-progress store is not performed.

## Test plan
- Reset:
  - Drive `reset`=0 asynchronously between edges → `pc`=0 and `memwrite`=0 immediately.
  - Release → `pc` sequences 0, 4, 8, …
- Back-to-back forwarding:
  - addi $2,$0,5; addi $3,$2,2; add $4,$2,$3; sw $4,80($0).
  - Expect `memwrite`=1 with `aluout`=80 (0x50) and `writedata`=12, with no stalls.
- Load-use:
  - sw $4,84($0); lw $5,84($0); add $6,$5,$5; sw $6,88($0).
  - Expect exactly one stall cycle (`pc` held once), then a store of 24 to address 88.
- beq taken:
  - beq $0,$0,+1 followed by addi $7,$0,1, then sw $7,92($0).
  - The addi is squashed: the store writes 0 to address 92.
- beq not taken and Decode-compare stall:
  - addi $8,$0,3; beq $8,$0,+2.
  - Expect a one-cycle stall, branch not taken, and execution falls through.
- j and ALU coverage:
  - j to 0x40; a program at 0x40 computes sub 7-12 → 0xFFFFFFFB, slt(-5,3)=1, and/or of 0xC,0xA → 8/0xE, storing each result.
  - `writedata` shows those exact values; the instruction after j is squashed.

Source files
------------

// File: rtl/mips_pipelined_core.sv
// Five-stage MIPS32-subset pipeline (F/D/E/M/W) with forwarding, load-use and
// branch-compare stalls, and branch/jump resolution in Decode with a one-slot squash.
module mips_pipelined_core (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        memwrite,
    output logic [31:0] aluout,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                           OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                           ALU_OR = 3'd3, ALU_SLT = 3'd4;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic        alusrc;
        logic [2:0]  alu;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wreg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } de_t;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic [4:0]  wreg;
        logic [31:0] alu_y;
        logic [31:0] wdata;
    } em_t;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [4:0]  wreg;
        logic [31:0] alu_y;
        logic [31:0] rdata;
    } mw_t;

    logic [31:0] pc_q, pc_d;
    logic [31:0] fd_instr_q, fd_instr_d;
    logic [31:0] fd_pcp4_q, fd_pcp4_d;
    de_t         de_q, de_d;
    em_t         em_q, em_d;
    mw_t         mw_q, mw_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Decode-stage fields and control
    logic [5:0]  d_op, d_funct;
    logic [4:0]  d_rs, d_rt, d_rd;
    logic [31:0] d_imm, d_rd1, d_rd2, br_a, br_b, target;
    logic        c_regwrite, c_memtoreg, c_memwrite, c_alusrc, c_branch, c_jump, c_use_rd;
    logic [2:0]  c_alu;
    logic        lu_stall, br_stall, stall, redirect;
    logic [31:0] wb_result;
    logic        wb_we;
    logic [31:0] e_fa, e_fb, e_b, e_y;

    assign d_op      = fd_instr_q[31:26];
    assign d_rs      = fd_instr_q[25:21];
    assign d_rt      = fd_instr_q[20:16];
    assign d_rd      = fd_instr_q[15:11];
    assign d_funct   = fd_instr_q[5:0];
    assign d_imm     = {{16{fd_instr_q[15]}}, fd_instr_q[15:0]};
    assign wb_result = mw_q.memtoreg ? mw_q.rdata : mw_q.alu_y;
    assign wb_we     = mw_q.regwrite && (mw_q.wreg != 5'd0);

    // Instruction decode; unsupported opcodes/functs fall through as nops
    always_comb begin
        c_regwrite = 1'b0;
        c_memtoreg = 1'b0;
        c_memwrite = 1'b0;
        c_alusrc   = 1'b0;
        c_branch   = 1'b0;
        c_jump     = 1'b0;
        c_use_rd   = 1'b0;
        c_alu      = ALU_ADD;
        case (d_op)
            OP_RTYPE: begin
                c_use_rd   = 1'b1;
                c_regwrite = 1'b1;
                case (d_funct)
                    6'h20:   c_alu = ALU_ADD;
                    6'h22:   c_alu = ALU_SUB;
                    6'h24:   c_alu = ALU_AND;
                    6'h25:   c_alu = ALU_OR;
                    6'h2A:   c_alu = ALU_SLT;
                    default: c_regwrite = 1'b0;
                endcase
            end
            OP_LW:   begin c_regwrite = 1'b1; c_memtoreg = 1'b1; c_alusrc = 1'b1; end
            OP_SW:   begin c_memwrite = 1'b1; c_alusrc = 1'b1; end
            OP_ADDI: begin c_regwrite = 1'b1; c_alusrc = 1'b1; end
            OP_BEQ:  c_branch = 1'b1;
            OP_J:    c_jump = 1'b1;
            default: ;
        endcase
    end

    // Register reads with write-through, branch operand forwarding and hazard detection
    always_comb begin
        d_rd1 = (d_rs == 5'd0) ? 32'd0 : (wb_we && mw_q.wreg == d_rs) ? wb_result : regs_q[d_rs];
        d_rd2 = (d_rt == 5'd0) ? 32'd0 : (wb_we && mw_q.wreg == d_rt) ? wb_result : regs_q[d_rt];
        br_a  = (em_q.regwrite && em_q.wreg != 5'd0 && em_q.wreg == d_rs) ? em_q.alu_y : d_rd1;
        br_b  = (em_q.regwrite && em_q.wreg != 5'd0 && em_q.wreg == d_rt) ? em_q.alu_y : d_rd2;
        lu_stall = de_q.memtoreg && (de_q.rt == d_rs || de_q.rt == d_rt);
        br_stall = c_branch &&
                   ((de_q.regwrite && (de_q.wreg == d_rs || de_q.wreg == d_rt)) ||
                    (em_q.memtoreg && (em_q.wreg == d_rs || em_q.wreg == d_rt)));
        stall    = lu_stall || br_stall;
        // A stall defers the branch decision to the next cycle
        redirect = !stall && (c_jump || (c_branch && br_a == br_b));
        target   = c_jump ? {fd_pcp4_q[31:28], fd_instr_q[25:0], 2'b00}
                          : fd_pcp4_q + {d_imm[29:0], 2'b00};
    end

    // Fetch, F/D and D/E next state: hold on stall, squash Fetch on redirect
    always_comb begin
        pc_d       = pc_q + 32'd4;
        fd_instr_d = instr;
        fd_pcp4_d  = pc_q + 32'd4;
        de_d       = '{regwrite: c_regwrite, memtoreg: c_memtoreg, memwrite: c_memwrite,
                       alusrc: c_alusrc, alu: c_alu, rs: d_rs, rt: d_rt,
                       wreg: c_use_rd ? d_rd : d_rt, a: d_rd1, b: d_rd2, imm: d_imm};
        if (stall) begin
            pc_d       = pc_q;
            fd_instr_d = fd_instr_q;
            fd_pcp4_d  = fd_pcp4_q;
            de_d       = '0;
        end else if (redirect) begin
            pc_d       = target;
            fd_instr_d = 32'd0;
        end
    end

    // Execute with Memory-over-Writeback operand forwarding, then E/M and M/W next state
    always_comb begin
        e_fa = (em_q.regwrite && em_q.wreg != 5'd0 && em_q.wreg == de_q.rs) ? em_q.alu_y :
               (wb_we && mw_q.wreg == de_q.rs) ? wb_result : de_q.a;
        e_fb = (em_q.regwrite && em_q.wreg != 5'd0 && em_q.wreg == de_q.rt) ? em_q.alu_y :
               (wb_we && mw_q.wreg == de_q.rt) ? wb_result : de_q.b;
        e_b  = de_q.alusrc ? de_q.imm : e_fb;
        case (de_q.alu)
            ALU_SUB: e_y = e_fa - e_b;
            ALU_AND: e_y = e_fa & e_b;
            ALU_OR:  e_y = e_fa | e_b;
            ALU_SLT: e_y = ($signed(e_fa) < $signed(e_b)) ? 32'd1 : 32'd0;
            default: e_y = e_fa + e_b;
        endcase
        em_d = '{regwrite: de_q.regwrite, memtoreg: de_q.memtoreg, memwrite: de_q.memwrite,
                 wreg: de_q.wreg, alu_y: e_y, wdata: e_fb};
        mw_d = '{regwrite: em_q.regwrite, memtoreg: em_q.memtoreg, wreg: em_q.wreg,
                 alu_y: em_q.alu_y, rdata: readdata};
        regs_d = regs_q;
        if (wb_we) regs_d[mw_q.wreg] = wb_result;
    end

    // All architectural and pipeline state; reset aborts everything in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= '0;
            fd_instr_q <= '0;
            fd_pcp4_q  <= '0;
            de_q       <= '0;
            em_q       <= '0;
            mw_q       <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            pc_q       <= pc_d;
            fd_instr_q <= fd_instr_d;
            fd_pcp4_q  <= fd_pcp4_d;
            de_q       <= de_d;
            em_q       <= em_d;
            mw_q       <= mw_d;
            regs_q     <= regs_d;
        end
    end

    assign pc        = pc_q;
    assign memwrite  = em_q.memwrite;
    assign aluout    = em_q.alu_y;
    assign writedata = em_q.wdata;
endmodule

// File: tb/tb_mips_pipelined_core.sv
// Bench for mips_pipelined_core: program table with expected stores fed to a
// scoreboard, a PC trace for stall/redirect timing, and asynchronous reset checks.
module tb_mips_pipelined_core;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, instr, aluout, writedata, readdata;
    logic        memwrite;

    typedef struct {
        logic [31:0] instr;
        bit          st;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    vec_t        prog [33];
    exp_t        sb [$];
    exp_t        got;
    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic        dmem_clr;
    logic        mon_en;
    int          cyc;
    int          tests = 0;
    int          fails = 0;
    localparam logic [31:0] SENTINEL = 32'hDEADBEEF;

    logic [31:0] pc_trace [19] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
                                   32'h1C, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30,
                                   32'h34, 32'h34, 32'h38, 32'h40, 32'h44};

    mips_pipelined_core dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .instr     (instr),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata)
    );

    always #5 clk = ~clk;

    assign instr    = imem[pc[7:2]];
    assign readdata = dmem[aluout[7:2]];

    // Data memory: synchronous write, bench-controlled clear
    always @(posedge clk) begin
        if (dmem_clr) begin
            for (int i = 0; i < 64; i++) dmem[i] <= SENTINEL;
        end else if (memwrite) begin
            dmem[aluout[7:2]] <= writedata;
        end
    end

    // Cycle index since reset release (cycle 0 fetches address 0)
    always @(posedge clk) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] jtype(input int tgt);
        return {6'h02, 26'(tgt)};
    endfunction

    task automatic put(input int a, input logic [31:0] w, input bit st,
                       input logic [31:0] ad, input logic [31:0] dt, input int c);
        prog[a >> 2] = '{w, st, ad, dt, c};
    endtask

    // Scoreboard: every store the core issues must match the next expected one
    always @(negedge clk) begin
        if (mon_en && reset && memwrite) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_store: got addr 0x%08h data 0x%08h expected none",
                         aluout, writedata);
            end else begin
                got = sb.pop_front();
                $display("[TB] store cycle %0d addr 0x%08h data 0x%08h", cyc, aluout, writedata);
                check("store_addr", aluout, got.addr);
                check("store_data", writedata, got.data);
                check("store_cycle", 32'(cyc), 32'(got.cyc));
            end
        end
    end

    initial begin
        reset    = 1'b1;
        dmem_clr = 1'b1;
        mon_en   = 1'b0;

        for (int i = 0; i < 33; i++) prog[i] = '{32'd0, 1'b0, 32'd0, 32'd0, 0};
        put(32'h00, itype(8, 0, 2, 5),             0, 0, 0, 0);
        put(32'h04, itype(8, 2, 3, 2),             0, 0, 0, 0);
        put(32'h08, rtype(2, 3, 4, 'h20),          0, 0, 0, 0);
        put(32'h0C, itype('h2B, 0, 4, 80),         1, 80, 12, 6);
        put(32'h10, itype('h2B, 0, 4, 84),         1, 84, 12, 7);
        put(32'h14, itype('h23, 0, 5, 84),         0, 0, 0, 0);
        put(32'h18, rtype(5, 5, 6, 'h20),          0, 0, 0, 0);
        put(32'h1C, itype('h2B, 0, 6, 88),         1, 88, 24, 11);
        put(32'h20, itype(4, 0, 0, 1),             0, 0, 0, 0);
        put(32'h24, itype(8, 0, 7, 1),             0, 0, 0, 0);
        put(32'h28, itype('h2B, 0, 7, 92),         1, 92, 0, 14);
        put(32'h2C, itype(8, 0, 8, 3),             0, 0, 0, 0);
        put(32'h30, itype(4, 8, 0, 2),             0, 0, 0, 0);
        put(32'h34, jtype('h10),                   0, 0, 0, 0);
        put(32'h38, itype(8, 0, 9, 1),             0, 0, 0, 0);
        put(32'h40, itype(8, 0, 10, 7),            0, 0, 0, 0);
        put(32'h44, itype(8, 0, 11, 12),           0, 0, 0, 0);
        put(32'h48, rtype(10, 11, 12, 'h22),       0, 0, 0, 0);
        put(32'h4C, itype('h2B, 0, 12, 96),        1, 96, 32'hFFFFFFFB, 23);
        put(32'h50, itype(8, 0, 13, 3),            0, 0, 0, 0);
        put(32'h54, rtype(12, 13, 14, 'h2A),       0, 0, 0, 0);
        put(32'h58, itype('h2B, 0, 14, 100),       1, 100, 1, 26);
        put(32'h5C, itype(8, 0, 15, 12),           0, 0, 0, 0);
        put(32'h60, itype(8, 0, 16, 10),           0, 0, 0, 0);
        put(32'h64, rtype(15, 16, 17, 'h24),       0, 0, 0, 0);
        put(32'h68, rtype(15, 16, 18, 'h25),       0, 0, 0, 0);
        put(32'h6C, itype('h2B, 0, 17, 104),       1, 104, 8, 31);
        put(32'h70, itype('h2B, 0, 18, 108),       1, 108, 32'hE, 32);
        put(32'h74, itype('h0D, 0, 9, 'h55),       0, 0, 0, 0);
        put(32'h78, rtype(0, 15, 9, 'h26),         0, 0, 0, 0);
        put(32'h7C, itype('h2B, 0, 9, 112),        1, 112, 0, 35);
        put(32'h80, jtype('h20),                   0, 0, 0, 0);

        for (int i = 0; i < 64; i++) imem[i] = (i < 33) ? prog[i].instr : 32'd0;

        // Asynchronous reset between edges, before any clock has run
        #1 reset = 1'b0;
        #2;
        check("reset_pc", pc, 32'd0);
        check("reset_memwrite", 32'(memwrite), 32'd0);
        check("reset_aluout", aluout, 32'd0);
        check("reset_writedata", writedata, 32'd0);

        // Run into the first store, then abort it with a mid-cycle reset
        @(posedge clk);
        @(negedge clk);
        dmem_clr = 1'b0;
        reset    = 1'b1;
        repeat (6) @(negedge clk);
        check("live_store_memwrite", 32'(memwrite), 32'd1);
        check("live_store_addr", aluout, 32'd80);
        #2 reset = 1'b0;
        #1;
        check("abort_pc", pc, 32'd0);
        check("abort_memwrite", 32'(memwrite), 32'd0);
        check("abort_aluout", aluout, 32'd0);
        check("abort_writedata", writedata, 32'd0);
        @(posedge clk);
        #1;
        check("abort_no_write", dmem[20], SENTINEL);

        // Fresh run: memory cleared, expected stores queued from the table
        dmem_clr = 1'b1;
        @(posedge clk);
        #1 dmem_clr = 1'b0;
        for (int i = 0; i < 33; i++)
            if (prog[i].st) sb.push_back('{prog[i].addr, prog[i].data, prog[i].cyc});
        mon_en = 1'b1;
        @(negedge clk);
        reset = 1'b1;

        // PC trace covers the load-use stall, beq squash, beq stall and j redirect
        for (int k = 0; k < 19; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("pc_c%0d", k), pc, pc_trace[k]);
        end

        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        check("stores_drained", 32'(sb.size()), 32'd0);
        repeat (5) @(negedge clk);
        check("squashed_addi_mem", dmem[23], 32'd0);
        check("sub_result_mem", dmem[24], 32'hFFFFFFFB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
